// File: rtl/tb_clock_monitor_if.sv
// Signal bundle between a clock-monitor client and the tb_clock_monitor core.
// Carries run control, the monitored clock, the phase limits and the results.
// CLK and RST stay plain ports on the core and are not part of this bundle.
interface tb_clock_monitor_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       tb_status;
  logic             MON;
  logic [CNT_W-1:0] high_min;
  logic [CNT_W-1:0] high_max;
  logic [CNT_W-1:0] low_min;
  logic [CNT_W-1:0] low_max;
  logic [CNT_W-1:0] stuck_limit;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic             meas_valid;
  logic             err_high;
  logic             err_low;
  logic             err_stuck;

  // Client side: drives control and limits, observes results.
  modport master (
    output tb_status, MON, high_min, high_max, low_min, low_max, stuck_limit,
    input  high_cnt, low_cnt, meas_valid, err_high, err_low, err_stuck
  );

  // Monitor core side.
  modport slave (
    input  tb_status, MON, high_min, high_max, low_min, low_max, stuck_limit,
    output high_cnt, low_cnt, meas_valid, err_high, err_low, err_stuck
  );
endinterface

// File: rtl/tb_clock_monitor.sv
// Clock monitor: measures the high and low phase lengths of MON in CLK
// cycles, reports each completed period, and flags out-of-range or stuck
// phases with sticky error bits.
// Build option: define TB_CLOCK_MONITOR_SYNC_EN to put MON through a
// two-flop synchronizer (2-cycle input latency); otherwise MON is
// registered once (1-cycle latency). Measured counts are the same either way.
module tb_clock_monitor #(
  parameter int CNT_W = 16
) (
  input  logic            CLK,
  input  logic            RST,
  tb_clock_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_next;

  logic             r_ms;
  logic             r_ms_d;
  logic             r_run_d;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hc;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_low_cnt;
  logic             r_meas_valid;
  logic             r_err_high;
  logic             r_err_low;
  logic             r_err_stuck;

  logic             w_run;
  logic             w_run_rise;
  logic             w_rise;
  logic             w_cnt_clr;
  logic             w_cnt_load;
  logic             w_cnt_inc;
  logic             w_hc_latch;
  logic             w_meas;
  logic             w_err_clr;
  logic             w_stuck_hit;
  logic             w_high_bad;
  logic             w_low_bad;
  logic [CNT_W-1:0] w_cnt_sat_inc;

`ifdef TB_CLOCK_MONITOR_SYNC_EN
  logic r_sync1;

  // Two-flop synchronizer; the second flop is the sampled monitor level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_ms    <= 1'b0;
    end else begin
      r_sync1 <= bus.MON;
      r_ms    <= r_sync1;
    end
  end
`else
  // Single input register for the monitored clock.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ms <= 1'b0;
    end else begin
      r_ms <= bus.MON;
    end
  end
`endif

  // Delayed copies for MON rise detection and run-start detection.
  // r_run_d resets to 1 so a run held high through reset is not taken as a
  // fresh start; a genuine 0->1 on tb_status[0] is needed after release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ms_d  <= 1'b0;
      r_run_d <= 1'b1;
    end else begin
      r_ms_d  <= r_ms;
      r_run_d <= w_run;
    end
  end

  assign w_run      = bus.tb_status[0];
  assign w_run_rise = w_run & ~r_run_d;
  assign w_rise     = r_ms & ~r_ms_d;

  assign w_cnt_sat_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  // Range checks use the values about to be published as high_cnt/low_cnt.
  assign w_high_bad = (r_hc  < bus.high_min) || (r_hc  > bus.high_max);
  assign w_low_bad  = (r_cnt < bus.low_min)  || (r_cnt > bus.low_max);

  // A zero stuck limit disables the check; ARM and IDLE never count phases.
  assign w_stuck_hit = ((r_state == ST_HIGH) || (r_state == ST_LOW)) &&
                       (bus.stuck_limit != '0) &&
                       (r_cnt == bus.stuck_limit);

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control; losing run overrides everything.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_inc    = 1'b0;
    w_hc_latch   = 1'b0;
    w_meas       = 1'b0;
    w_err_clr    = 1'b0;
    if (!w_run) begin
      w_state_next = ST_IDLE;
      w_cnt_clr    = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_run_rise) begin
            w_state_next = ST_ARM;
            w_err_clr    = 1'b1;
          end
        end
        ST_ARM: begin
          // Wait for the first rise; this first high phase starts the
          // measurement but is never reported on its own.
          if (w_rise) begin
            w_state_next = ST_HIGH;
            w_cnt_load   = 1'b1;
          end
        end
        ST_HIGH: begin
          if (r_ms) begin
            w_cnt_inc = 1'b1;
          end else begin
            w_hc_latch   = 1'b1;
            w_cnt_load   = 1'b1;
            w_state_next = ST_LOW;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            w_meas       = 1'b1;
            w_cnt_load   = 1'b1;
            w_state_next = ST_HIGH;
          end else if (!r_ms) begin
            w_cnt_inc = 1'b1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Phase counter and holding register for the completed high phase.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
      r_hc  <= '0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_load) begin
        r_cnt <= CNT_ONE;
      end else if (w_cnt_inc) begin
        r_cnt <= w_cnt_sat_inc;
      end
      if (w_hc_latch) begin
        r_hc <= r_cnt;
      end
    end
  end

  // Published measurement and its one-cycle valid pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_high_cnt   <= '0;
      r_low_cnt    <= '0;
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= w_meas;
      if (w_meas) begin
        r_high_cnt <= r_hc;
        r_low_cnt  <= r_cnt;
      end
    end
  end

  // Sticky error flags; cleared only by reset or a new run start.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err_high  <= 1'b0;
      r_err_low   <= 1'b0;
      r_err_stuck <= 1'b0;
    end else if (w_err_clr) begin
      r_err_high  <= 1'b0;
      r_err_low   <= 1'b0;
      r_err_stuck <= 1'b0;
    end else begin
      if (w_meas && w_high_bad) begin
        r_err_high <= 1'b1;
      end
      if (w_meas && w_low_bad) begin
        r_err_low <= 1'b1;
      end
      if (w_stuck_hit) begin
        r_err_stuck <= 1'b1;
      end
    end
  end

  assign bus.high_cnt   = r_high_cnt;
  assign bus.low_cnt    = r_low_cnt;
  assign bus.meas_valid = r_meas_valid;
  assign bus.err_high   = r_err_high;
  assign bus.err_low    = r_err_low;
  assign bus.err_stuck  = r_err_stuck;

endmodule

// File: doc/tb_clock_monitor.md
TB_CLOCK_MONITOR -- requirements
Module: tb_clock_monitor

Interface
REQ-001 Parameter CNT_W, default 16, width of every phase counter and limit.
REQ-002 CLK  input  1  sampling clock, all state rising-edge on CLK.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 tb_status  input  2  bench status; bit0=1 means run, bit1 is ignored.
REQ-005 MON  input  1  monitored clock from the upstream clock generator; asynchronous to CLK.
REQ-006 high_min, high_max, low_min, low_max  input  CNT_W each  inclusive limits, in CLK cycles, for the high and low phases.
REQ-007 stuck_limit  input  CNT_W  maximum phase length, in CLK cycles, before a stuck error.
REQ-008 high_cnt, low_cnt  output  CNT_W each  last completed high and low phase lengths.
REQ-009 meas_valid  output  1  one-cycle pulse when high_cnt and low_cnt update.
REQ-010 err_high, err_low, err_stuck  output  1 each  sticky error flags.

Function
REQ-011 ms denotes MON after the input stage (REQ-029/030); ms_d denotes ms delayed one CLK; a rise is ms=1 with ms_d=0.
REQ-012 FSM states: IDLE, ARM, HIGH, LOW.
REQ-013 Any state with tb_status[0]=0 goes to IDLE next cycle; this overrides every other transition on the same cycle.
REQ-014 IDLE -> ARM on the cycle tb_status[0] is sampled 1 with the previous sample 0; the same cycle clears err_high, err_low and err_stuck.
REQ-015 ARM -> HIGH on a rise; the phase counter is loaded with 1.
REQ-016 HIGH: counter increments each cycle ms=1; on ms=0, the counter value latches into a holding register hc, the counter loads 1, and the state goes to LOW.
REQ-017 LOW: counter increments each cycle ms=0; on a rise, high_cnt<=hc, low_cnt<=counter, meas_valid=1 on the next cycle, the counter loads 1, and the state goes to HIGH.
REQ-018 The counter saturates at all-ones and never wraps.
REQ-019 Each meas_valid also sets err_high if high_cnt is outside [high_min,high_max], and sets err_low if low_cnt is outside [low_min,low_max].
REQ-020 In HIGH or LOW, when the counter equals stuck_limit, err_stuck sets; the state stays, and counting continues to saturation.
REQ-021 stuck_limit=0 disables stuck detection.
REQ-022 ARM never sets err_stuck.
REQ-023 meas_valid is never asserted in IDLE or ARM, or for the first, partial high phase.
REQ-024 The first meas_valid follows the second rise after ARM.
REQ-025 Error flags hold until RST or the next run start per REQ-014; they are not cleared by leaving run.
REQ-026 high_cnt and low_cnt hold their last values in IDLE.

Reset
REQ-027 RST asserted sets state=IDLE, counter=0, hc=0, high_cnt=0, low_cnt=0, meas_valid=0, err_high=0, err_low=0, err_stuck=0, ms=0, ms_d=0, and all synchronizer flops=0.
REQ-028 RST asserted mid-measurement discards the partial phase; after release, a new run requires a tb_status[0] 0->1 transition.

Configuration
REQ-029 Macro TB_CLOCK_MONITOR_SYNC_EN defined: MON passes through a two-flop synchronizer before ms, so total latency from a MON edge to ms is 2 CLK cycles.
REQ-030 Macro TB_CLOCK_MONITOR_SYNC_EN undefined: ms is MON registered once, so latency is 1 CLK cycle; measured counts are identical in both builds.

Verification
REQ-031 MON is 4 CLK high / 6 CLK low, phase-aligned to CLK; limits are high [3,5], low [5,7]; stuck_limit=20; run is set. Required: meas_valid every 10 cycles, high_cnt=4, low_cnt=6, no errors.
REQ-032 Same setup with MON switched to 7 high / 3 low. Required: the next meas_valid gives high_cnt=7 and low_cnt=3, and err_high=1 and err_low=1 remain set after MON is restored.
REQ-033 MON held at 1 with stuck_limit=20. Required: err_stuck=1 exactly 20 cycles after the counter loads 1, and meas_valid stays 0.
REQ-034 tb_status[0] dropped during LOW, then re-raised. Required: IDLE next cycle, no meas_valid, errors cleared on re-raise, and the first meas_valid after the second rise.
REQ-035 RST pulsed mid-HIGH. Required: all outputs 0 immediately, and no activity until a tb_status[0] 0->1 transition.
REQ-036 CNT_W=4, MON 20 high / 20 low, stuck_limit=0. Required: high_cnt=15 and low_cnt=15 (saturated), and err_stuck=0.
